bcd_step_sequencer: RTL and testbench

// - Serial controller for packed-BCD increment/decrement of a DIGITS-wide operand.
// - Walks the operand one digit per cycle, least-significant digit first, through a single

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_step.sv | 42 ++++
 rtl/bcd_step_sequencer.sv | 107 ++++++++++
 tb/tb_bcd_step_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// +-----------------------------------------------------------------------------+
// | bcd_pkg: shared types and digit bounds for the serial BCD step sequencer.    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_seq_state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit_step.sv
// +-----------------------------------------------------------------------------+
// | bcd_digit_step: combinational +/-1 adjust of one BCD digit with carry/borrow. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t d_i,
    input  logic       c_i,
    input  logic       dec_i,
    output bcd_digit_t d_o,
    output logic       co_o
);

    // Digits above 9 follow the same rules: >=9 wraps on increment.
    always_comb begin
        d_o  = d_i;
        co_o = 1'b0;
        if (c_i) begin
            if (dec_i) begin
                if (d_i == BCD_MIN) begin
                    d_o  = BCD_MAX;
                    co_o = 1'b1;
                end else begin
                    d_o = d_i - 4'd1;
                end
            end else begin
                if (d_i >= BCD_MAX) begin
                    d_o  = BCD_MIN;
                    co_o = 1'b1;
                end else begin
                    d_o = d_i + 4'd1;
                end
            end
        end
    end

endmodule : bcd_digit_step

`default_nettype wire

// File: rtl/bcd_step_sequencer.sv
// +-----------------------------------------------------------------------------+
// | bcd_step_sequencer: serial packed-BCD inc/dec, one digit per cycle, LSD first.|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module bcd_step_sequencer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_value,
    input  logic                  in_dec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_value,
    output logic                  out_carry
);

    localparam int IDXW = $clog2(DIGITS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    bcd_seq_state_t        state_q;
    logic [4*DIGITS-1:0]   work_q;
    logic [IDXW-1:0]       idx_q;
    logic                  carry_q;
    logic                  dec_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    bcd_digit_t            digit_cur;
    bcd_digit_t            digit_d;
    logic                  carry_d;

    assign digit_cur = work_q[4*idx_q +: 4];

    bcd_digit_step u_step (
        .d_i   (digit_cur),
        .c_i   (carry_q),
        .dec_i (dec_q),
        .d_o   (digit_d),
        .co_o  (carry_d)
    );

    // The work register is the result register; it is only rewritten by a new operand.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            dec_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= in_value;
                        dec_q      <= in_dec;
                        carry_q    <= 1'b1;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    work_q[4*idx_q +: 4] <= digit_d;
                    carry_q              <= carry_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle raises out_valid; out_ready counts only once it is up.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_value = work_q;
    assign out_carry = carry_q;

endmodule : bcd_step_sequencer

`default_nettype wire

// File: tb/tb_bcd_step_sequencer.sv
// +-----------------------------------------------------------------------------+
// | tb_bcd_step_sequencer: scoreboard bench with integer-arithmetic BCD model.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_bcd_step_sequencer;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_value;
    logic         in_dec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_value;
    logic         out_carry;

    int n_checks;
    int n_fail;

    logic [W:0] sb[$];

    bcd_step_sequencer #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_dec    (in_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_carry (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden model: treat the operand as a decimal integer and step it modulo 10^DIGITS.
    function automatic logic [W:0] model(input logic [W-1:0] v, input logic dec);
        int n;
        int lim;
        logic c;
        logic [W-1:0] r;
        n = 0;
        lim = 1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            n = n * 10 + int'(v[4*i +: 4]);
            lim = lim * 10;
        end
        c = 1'b0;
        if (dec) begin
            if (n == 0) begin n = lim - 1; c = 1'b1; end
            else n = n - 1;
        end else begin
            if (n == lim - 1) begin n = 0; c = 1'b1; end
            else n = n + 1;
        end
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return {c, r};
    endfunction

    // Monitor: pops on each handshake and checks held results stay stable while stalled.
    logic         hold_v;
    logic [W:0]   hold_val;
    logic [W:0]   exp_pop;
    initial hold_v = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            hold_v = 1'b0;
        end else if (out_valid) begin
            if (hold_v) chk("stall_stable", {15'd0, out_carry, out_value}, {15'd0, hold_val});
            if (out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_pop = sb.pop_front();
                    chk("out_value", 32'(out_value), 32'(exp_pop[W-1:0]));
                    chk("out_carry", 32'(out_carry), 32'(exp_pop[W]));
                end
                hold_v = 1'b0;
            end else begin
                hold_v   = 1'b1;
                hold_val = {out_carry, out_value};
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] v, input logic d, input logic [W:0] exp);
        int k;
        in_valid = 1'b1;
        in_value = v;
        in_dec   = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 200);
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        else sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = W'($urandom);
        in_dec   = 1'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        int mode;
        mode = int'($urandom_range(0, 7));
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if (mode == 0) r = '0;
        else if (mode == 1) r = {DIGITS{4'h9}};
        else if (mode == 2) r[7:0] = 8'h99;
        else if (mode == 3) r[7:0] = 8'h00;
        return r;
    endfunction

    initial begin
        int lat;
        bit done;
        logic [W-1:0] v;
        logic d;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        in_dec    = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_value", 32'(out_value), 32'd0);
        chk("reset_out_carry", 32'(out_carry), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(16'h0199, 1'b0, {1'b0, 16'h0200});
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk("latency", 32'(lat), 32'd5);
        drain();

        send(16'h1000, 1'b1, {1'b0, 16'h0999});
        drain();
        send(16'h0000, 1'b1, {1'b1, 16'h9999});
        drain();

        // Backpressure on an increment that wraps.
        out_ready = 1'b0;
        send(16'h9999, 1'b0, {1'b1, 16'h0000});
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_value", 32'(out_value), 32'h0000);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid), 32'd0);
        drain();

        // Reset two cycles into RUN: the pending result must never appear.
        send(16'h1234, 1'b0, {1'b0, 16'h1235});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_value", 32'(out_value), 32'd0);
        chk("midrst_out_carry", 32'(out_carry), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_pulse", 32'(out_valid), 32'd0);
        send(16'h0009, 1'b0, {1'b0, 16'h0010});
        drain();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    v = rand_bcd();
                    d = 1'($urandom);
                    send(v, d, model(v, d));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_bcd_step_sequencer

`default_nettype wire
